// File: rtl/apb4_to_passthrough_cpuif.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// apb4_to_passthrough_cpuif
//
// Bridges an APB4 completer port onto the register block passthrough cpuif
// request/response strobes. Each APB transfer becomes exactly one cpuif
// request; PREADY stays low until the matching ack arrives or the wait times
// out.
//
// Parameters
//   ADDR_W   byte address width on both sides
//   DATA_W   data width (8/16/32/64)
//   TIMEOUT  cycles to wait for an ack after the request is accepted;
//            0 waits forever
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   s_apb_*           APB4 completer port (psel/penable/pwrite/paddr/pwdata/
//                     pstrb in, pready/prdata/pslverr out)
//   m_req             cpuif request strobe, held while stalled
//   m_req_is_wr       request is a write
//   m_addr            word-aligned request address
//   m_wr_data         write data (0 for reads)
//   m_wr_biten        per-bit write enable from pstrb (0 for reads)
//   m_req_stall_wr/rd regblock cannot accept a write/read this cycle
//   m_rd_ack/err/data read response
//   m_wr_ack/err      write response
//   timeout_pulse     one-cycle pulse when a transfer times out
// -----------------------------------------------------------------------------
module apb4_to_passthrough_cpuif #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_apb_psel,
  input  logic                s_apb_penable,
  input  logic                s_apb_pwrite,
  input  logic [ADDR_W-1:0]   s_apb_paddr,
  input  logic [DATA_W-1:0]   s_apb_pwdata,
  input  logic [DATA_W/8-1:0] s_apb_pstrb,
  output logic                s_apb_pready,
  output logic [DATA_W-1:0]   s_apb_prdata,
  output logic                s_apb_pslverr,
  output logic                m_req,
  output logic                m_req_is_wr,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wr_data,
  output logic [DATA_W-1:0]   m_wr_biten,
  input  logic                m_req_stall_wr,
  input  logic                m_req_stall_rd,
  input  logic                m_rd_ack,
  input  logic                m_rd_err,
  input  logic [DATA_W-1:0]   m_rd_data,
  input  logic                m_wr_ack,
  input  logic                m_wr_err,
  output logic                timeout_pulse
);

  localparam int unsigned BYTE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(BYTE_W - 1));

  // Counter holds 0..TIMEOUT-1; the last WAIT cycle is the one where it
  // equals TIMEOUT-1, so exactly TIMEOUT WAIT cycles elapse before giving up.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                state_q;
  logic                  wr_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [BYTE_W-1:0]     strb_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;
  logic                  timed_out_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  stall_dir;
  logic                  ack_dir;
  logic                  err_dir;
  logic [DATA_W-1:0]     biten;

  // Only the response channel matching the captured direction is observed;
  // the other channel is ignored entirely.
  always_comb begin
    stall_dir = wr_q ? m_req_stall_wr : m_req_stall_rd;
    ack_dir   = wr_q ? m_wr_ack       : m_rd_ack;
    err_dir   = wr_q ? m_wr_err       : m_rd_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      timed_out_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s_apb_psel && !s_apb_penable) begin
            wr_q        <= s_apb_pwrite;
            addr_q      <= s_apb_paddr;
            wdata_q     <= s_apb_pwdata;
            strb_q      <= s_apb_pstrb;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            timed_out_q <= 1'b0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!stall_dir) begin
            cnt_q <= '0;
            if (ack_dir) begin
              rdata_q <= wr_q ? '0 : m_rd_data;
              err_q   <= err_dir;
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (ack_dir) begin
            rdata_q <= wr_q ? '0 : m_rd_data;
            err_q   <= err_dir;
            state_q <= ST_RESP;
          end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
            rdata_q     <= '0;
            err_q       <= 1'b1;
            timed_out_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    biten = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      biten[i] = strb_q[i / 8];
    end
  end

  always_comb begin
    m_req       = (state_q == ST_ISSUE);
    m_req_is_wr = wr_q;
    m_addr      = addr_q & ADDR_MASK;
    m_wr_data   = wr_q ? wdata_q : '0;
    m_wr_biten  = wr_q ? biten   : '0;
  end

  // If the requester has already dropped psel, the response cycle passes
  // without pready and the bridge simply returns to IDLE.
  always_comb begin
    s_apb_pready  = (state_q == ST_RESP) && s_apb_psel;
    s_apb_prdata  = s_apb_pready ? rdata_q : '0;
    s_apb_pslverr = s_apb_pready && err_q;
    timeout_pulse = (state_q == ST_RESP) && timed_out_q;
  end

endmodule

// File: tb/tb_apb4_to_passthrough_cpuif.sv
`timescale 1ns/1ps
module tb_apb4_to_passthrough_cpuif;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 64;

  logic          clk;
  logic          rst;
  logic          s_apb_psel;
  logic          s_apb_penable;
  logic          s_apb_pwrite;
  logic [AW-1:0] s_apb_paddr;
  logic [DW-1:0] s_apb_pwdata;
  logic [3:0]    s_apb_pstrb;
  logic          s_apb_pready;
  logic [DW-1:0] s_apb_prdata;
  logic          s_apb_pslverr;
  logic          m_req;
  logic          m_req_is_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wr_data;
  logic [DW-1:0] m_wr_biten;
  logic          m_req_stall_wr;
  logic          m_req_stall_rd;
  logic          m_rd_ack;
  logic          m_rd_err;
  logic [DW-1:0] m_rd_data;
  logic          m_wr_ack;
  logic          m_wr_err;
  logic          timeout_pulse;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  apb4_to_passthrough_cpuif #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_apb_psel    (s_apb_psel),
    .s_apb_penable (s_apb_penable),
    .s_apb_pwrite  (s_apb_pwrite),
    .s_apb_paddr   (s_apb_paddr),
    .s_apb_pwdata  (s_apb_pwdata),
    .s_apb_pstrb   (s_apb_pstrb),
    .s_apb_pready  (s_apb_pready),
    .s_apb_prdata  (s_apb_prdata),
    .s_apb_pslverr (s_apb_pslverr),
    .m_req         (m_req),
    .m_req_is_wr   (m_req_is_wr),
    .m_addr        (m_addr),
    .m_wr_data     (m_wr_data),
    .m_wr_biten    (m_wr_biten),
    .m_req_stall_wr(m_req_stall_wr),
    .m_req_stall_rd(m_req_stall_rd),
    .m_rd_ack      (m_rd_ack),
    .m_rd_err      (m_rd_err),
    .m_rd_data     (m_rd_data),
    .m_wr_ack      (m_wr_ack),
    .m_wr_err      (m_wr_err),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Idle cycles with psel low and random stray acks on both channels:
  // nothing may be requested or completed.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_apb_psel     = 1'b0;
      s_apb_penable  = 1'b0;
      m_req_stall_wr = 1'($urandom_range(0, 1));
      m_req_stall_rd = 1'($urandom_range(0, 1));
      m_rd_ack       = 1'($urandom_range(0, 1));
      m_rd_err       = 1'($urandom_range(0, 1));
      m_wr_ack       = 1'($urandom_range(0, 1));
      m_wr_err       = 1'($urandom_range(0, 1));
      m_rd_data      = $urandom;
      #1;
      check("idle_m_req", 64'(m_req), 64'd0);
      check("idle_pready", 64'(s_apb_pready), 64'd0);
      check("idle_timeout_pulse", 64'(timeout_pulse), 64'd0);
    end
  endtask

  // One APB transfer, cycle 0 = setup phase.
  // Reference timing: the request is shown in cycles 1..acc (acc = stall+1,
  // acc is the accepting cycle). An ack 'dly' cycles after acceptance
  // (0 = same cycle) is honoured when dly <= TO and yields pready at acc+dly+1.
  // Otherwise TO waiting cycles pass and pready comes at acc+TO+1 with an error.
  // psel drops from cycle drop_at on (drop_at < 0: never).
  task automatic run_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int stall, input int dly,
                          input bit err, input logic [31:0] rdata, input int drop_at);
    int          acc;
    int          p;
    bit          tmo;
    bit          psel_now;
    bit          own_ack;
    bit          exp_req;
    bit          exp_rdy;
    logic [31:0] exp_biten;
    logic [31:0] exp_rdata;
    acc = stall + 1;
    tmo = (dly > TO);
    p   = tmo ? acc + TO + 1 : acc + dly + 1;
    for (int b = 0; b < 32; b++) exp_biten[b] = strb[b / 8];
    exp_rdata = (tmo || wr) ? 32'd0 : rdata;
    for (int c = 0; c <= p; c++) begin
      @(negedge clk);
      psel_now      = (drop_at < 0) || (c < drop_at);
      s_apb_psel    = psel_now;
      s_apb_penable = psel_now && (c > 0);
      s_apb_pwrite  = wr;
      s_apb_paddr   = addr;
      s_apb_pwdata  = wdata;
      s_apb_pstrb   = strb;
      // Matching ack at the scheduled cycle; strays in IDLE (c==0) and
      // RESP (c==p) must be dropped.
      own_ack = (!tmo && c == acc + dly) || c == 0 || c == p;
      if (wr) begin
        m_req_stall_wr = (c >= 1 && c <= stall);
        m_req_stall_rd = 1'($urandom_range(0, 1));
        m_wr_ack       = own_ack;
        m_wr_err       = (!tmo && c == acc + dly) ? err : 1'($urandom_range(0, 1));
        m_rd_ack       = 1'($urandom_range(0, 1));
        m_rd_err       = 1'($urandom_range(0, 1));
        m_rd_data      = $urandom;
      end else begin
        m_req_stall_rd = (c >= 1 && c <= stall);
        m_req_stall_wr = 1'($urandom_range(0, 1));
        m_rd_ack       = own_ack;
        m_rd_err       = (!tmo && c == acc + dly) ? err : 1'($urandom_range(0, 1));
        m_rd_data      = (!tmo && c == acc + dly) ? rdata : $urandom;
        m_wr_ack       = 1'($urandom_range(0, 1));
        m_wr_err       = 1'($urandom_range(0, 1));
      end
      #1;
      exp_req = (c >= 1 && c <= acc);
      exp_rdy = (c == p) && psel_now;
      check("m_req", 64'(m_req), 64'(exp_req));
      if (exp_req) begin
        check("m_req_is_wr", 64'(m_req_is_wr), 64'(wr));
        check("m_addr", 64'(m_addr), 64'(addr & 32'hFFFF_FFFC));
        check("m_wr_data", 64'(m_wr_data), wr ? 64'(wdata) : 64'd0);
        check("m_wr_biten", 64'(m_wr_biten), wr ? 64'(exp_biten) : 64'd0);
      end
      check("pready", 64'(s_apb_pready), 64'(exp_rdy));
      if (exp_rdy) begin
        check("prdata", 64'(s_apb_prdata), 64'(exp_rdata));
        check("pslverr", 64'(s_apb_pslverr), 64'(tmo | err));
      end
      check("timeout_pulse", 64'(timeout_pulse), 64'((c == p) && tmo));
    end
  endtask

  // Reset asserted while the bridge is waiting for an ack.
  task automatic reset_in_wait();
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      s_apb_psel     = (c < 4);
      s_apb_penable  = (c >= 1 && c < 4);
      s_apb_pwrite   = 1'b1;
      s_apb_paddr    = 32'h0000_0044;
      s_apb_pwdata   = 32'hA5A5_5A5A;
      s_apb_pstrb    = 4'hF;
      m_req_stall_wr = 1'b0;
      m_req_stall_rd = 1'b0;
      m_rd_ack       = 1'b0;
      m_wr_ack       = (c == 4);
      m_wr_err       = 1'b0;
      rst            = (c == 3);
      #1;
      if (c == 2) check("rstw_wait_no_req", 64'(m_req), 64'd0);
      if (c == 4) begin
        check("rstw_m_req", 64'(m_req), 64'd0);
        check("rstw_pready", 64'(s_apb_pready), 64'd0);
        check("rstw_m_addr", 64'(m_addr), 64'd0);
        check("rstw_m_wr_data", 64'(m_wr_data), 64'd0);
        check("rstw_timeout_pulse", 64'(timeout_pulse), 64'd0);
      end
    end
  endtask

  initial begin
    int stall;
    int dly;
    int r;
    int drop_at;
    rst            = 1'b1;
    s_apb_psel     = 1'b0;
    s_apb_penable  = 1'b0;
    s_apb_pwrite   = 1'b0;
    s_apb_paddr    = '0;
    s_apb_pwdata   = '0;
    s_apb_pstrb    = '0;
    m_req_stall_wr = 1'b0;
    m_req_stall_rd = 1'b0;
    m_rd_ack       = 1'b0;
    m_rd_err       = 1'b0;
    m_rd_data      = '0;
    m_wr_ack       = 1'b0;
    m_wr_err       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_m_req", 64'(m_req), 64'd0);
    check("rst_m_req_is_wr", 64'(m_req_is_wr), 64'd0);
    check("rst_m_addr", 64'(m_addr), 64'd0);
    check("rst_m_wr_data", 64'(m_wr_data), 64'd0);
    check("rst_m_wr_biten", 64'(m_wr_biten), 64'd0);
    check("rst_pready", 64'(s_apb_pready), 64'd0);
    check("rst_prdata", 64'(s_apb_prdata), 64'd0);
    check("rst_pslverr", 64'(s_apb_pslverr), 64'd0);
    check("rst_timeout_pulse", 64'(timeout_pulse), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011, 0, 1, 1'b0, 32'h0, -1);
    run_xfer(1'b0, 32'h13, 32'h0, 4'h0, 0, 2, 1'b0, 32'h1234, -1);
    run_xfer(1'b0, 32'h20, 32'h0, 4'h0, 5, 1, 1'b0, 32'hCAFE_0001, -1);
    run_xfer(1'b0, 32'h24, 32'h0, 4'h0, 0, TO + 100, 1'b0, 32'h0, -1);
    idle_cycles(2);
    run_xfer(1'b1, 32'h28, 32'h1357_9BDF, 4'hF, 0, 1, 1'b0, 32'h0, -1);
    run_xfer(1'b1, 32'h2C, 32'h0BAD_F00D, 4'b1010, 0, 0, 1'b1, 32'h0, -1);
    run_xfer(1'b0, 32'h30, 32'h0, 4'h0, 1, TO, 1'b0, 32'h7777_8888, -1);
    run_xfer(1'b1, 32'h34, 32'h1111_2222, 4'b0100, 0, 2, 1'b0, 32'h0, 2);
    reset_in_wait();
    run_xfer(1'b0, 32'h48, 32'h0, 4'h0, 0, 1, 1'b1, 32'h55AA_33CC, -1);

    // Randomised transfers
    for (int t = 0; t < 150; t++) begin
      stall = $urandom_range(0, 3);
      r     = $urandom_range(0, 19);
      if (r < 16)      dly = $urandom_range(0, 4);
      else if (r < 18) dly = TO;
      else             dly = TO + 1 + $urandom_range(0, 5);
      drop_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : -1;
      run_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
               stall, dly, 1'($urandom_range(0, 1)), $urandom, drop_at);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
